pll_lock_supervisor: RTL and testbench

//  Consumer end of the CC_PLL lock interface. Runs on the 10 MHz board reference clock.

---
 rtl/pll_lock_supervisor.sv | 175 +++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Supervises CC_PLL lock, holds downstream reset until lock is
//               stable, counts lock losses and flags a lock-timeout fault.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int SETTLE_CYCLES   = 1000,
    parameter int LOCK_TIMEOUT    = 100000,
    parameter int STDY_RST_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int BLINK_BIT       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             pll_stdy,
    output logic             stdy_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [2:0]       state,
    output logic             status_led
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RUN       = 3'd3,
        S_LOST      = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    localparam int c_timer_w = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_pulse_w = $clog2(STDY_RST_CYCLES + 1);
    localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_timer_w-1:0] c_settle_last  = c_timer_w'(SETTLE_CYCLES - 1);
    localparam logic [c_pulse_w-1:0] c_pulse_load   = c_pulse_w'(STDY_RST_CYCLES - 1);

    logic                 r_lk_meta;
    logic                 r_lk_s;
    logic                 r_st_meta;
    logic                 r_st_s;
    logic                 w_lock;
    state_t               r_state;
    logic [c_timer_w-1:0] r_timer;
    logic [c_pulse_w-1:0] r_pulse_cnt;
    logic                 r_stdy_rst;
    logic                 r_sys_rst;
    logic                 r_ready;
    logic                 r_fault;
    logic [CNT_W-1:0]     r_loss_cnt;
    logic [BLINK_BIT:0]   r_blink;
    logic                 w_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
            r_st_meta <= 1'b0;
            r_st_s    <= 1'b0;
            r_blink   <= '0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk_s    <= r_lk_meta;
            r_st_meta <= pll_stdy;
            r_st_s    <= r_st_meta;
            r_blink   <= r_blink + 1'b1;
        end
    end

    assign w_lock = r_lk_s & r_st_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_pulse_cnt <= '0;
            r_stdy_rst  <= 1'b0;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            // The stdy_rst pulse runs on its own counter so leaving WAIT_LOCK early never truncates it
            if (r_pulse_cnt != '0) begin
                r_pulse_cnt <= r_pulse_cnt - 1'b1;
            end else begin
                r_stdy_rst <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_state     <= S_WAIT_LOCK;
                    r_timer     <= '0;
                    r_stdy_rst  <= 1'b1;
                    r_pulse_cnt <= c_pulse_load;
                end
                S_WAIT_LOCK: begin
                    if (w_lock) begin
                        r_state <= S_SETTLE;
                        r_timer <= '0;
                    end else if (r_timer == c_timeout_last) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!w_lock) begin
                        r_state     <= S_WAIT_LOCK;
                        r_timer     <= '0;
                        r_stdy_rst  <= 1'b1;
                        r_pulse_cnt <= c_pulse_load;
                    end else if (r_timer == c_settle_last) begin
                        r_state   <= S_RUN;
                        r_sys_rst <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!w_lock) begin
                        r_state   <= S_LOST;
                        r_sys_rst <= 1'b1;
                        r_ready   <= 1'b0;
                        if (r_loss_cnt != '1) begin
                            r_loss_cnt <= r_loss_cnt + 1'b1;
                        end
                    end
                end
                S_LOST: begin
                    r_state     <= S_WAIT_LOCK;
                    r_timer     <= '0;
                    r_stdy_rst  <= 1'b1;
                    r_pulse_cnt <= c_pulse_load;
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_sys_rst <= 1'b1;
                    r_ready   <= 1'b0;
                    r_fault   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_led = 1'b0;
        case (r_state)
            S_RUN:                         w_led = 1'b1;
            S_FAULT:                       w_led = r_blink[BLINK_BIT-2];
            S_WAIT_LOCK, S_SETTLE, S_LOST: w_led = r_blink[BLINK_BIT];
            default:                       w_led = 1'b0;
        endcase
    end

    assign stdy_rst   = r_stdy_rst;
    assign sys_rst    = r_sys_rst;
    assign ready      = r_ready;
    assign fault      = r_fault;
    assign loss_cnt   = r_loss_cnt;
    assign state      = r_state;
    assign status_led = w_led;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Directed and randomized bench for pll_lock_supervisor against
//               a phase-timing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int SETTLE_CYCLES   = 8;
    localparam int LOCK_TIMEOUT    = 64;
    localparam int STDY_RST_CYCLES = 4;
    localparam int CNT_W           = 2;
    localparam int BLINK_BIT       = 3;

    localparam int M_IDLE = 0, M_WAIT = 1, M_SETTLE = 2, M_RUN = 3, M_LOST = 4, M_FAULT = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pll_locked = 1'b0;
    logic             pll_stdy = 1'b0;
    logic             stdy_rst;
    logic             sys_rst;
    logic             ready;
    logic             fault;
    logic [CNT_W-1:0] loss_cnt;
    logic [2:0]       state;
    logic             status_led;

    int n_total = 0;
    int n_pass  = 0;

    pll_lock_supervisor #(
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STDY_RST_CYCLES(STDY_RST_CYCLES),
        .CNT_W          (CNT_W),
        .BLINK_BIT      (BLINK_BIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_stdy  (pll_stdy),
        .stdy_rst  (stdy_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fault     (fault),
        .loss_cnt  (loss_cnt),
        .state     (state),
        .status_led(status_led)
    );

    always #5 clk = ~clk;

    // Reference model: phase + edges elapsed in phase, pulse as a time window, blink as edge count
    bit m_valid = 0;
    int m_mode, m_since, m_loss, m_blink, m_edge, m_pulse_start;
    bit m_pulse_seen, m_locked_now;
    bit m_lk0, m_lk1, m_st0, m_st1;

    task enter(input int md);
        m_mode  = md;
        m_since = 0;
        if (md == M_WAIT) begin
            m_pulse_start = m_edge;
            m_pulse_seen  = 1;
        end
        if (md == M_LOST && m_loss < (1 << CNT_W) - 1) m_loss++;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_mode = M_IDLE; m_since = 0; m_loss = 0; m_blink = 0;
            m_edge = 0; m_pulse_seen = 0; m_pulse_start = 0;
            m_lk0 = 0; m_lk1 = 0; m_st0 = 0; m_st1 = 0;
        end else begin
            m_locked_now = m_lk1 && m_st1;
            m_lk1 = m_lk0; m_lk0 = pll_locked;
            m_st1 = m_st0; m_st0 = pll_stdy;
            m_edge++; m_blink++; m_since++;
            case (m_mode)
                M_IDLE:   enter(M_WAIT);
                M_WAIT:   if (m_locked_now) enter(M_SETTLE);
                          else if (m_since == LOCK_TIMEOUT) enter(M_FAULT);
                M_SETTLE: if (!m_locked_now) enter(M_WAIT);
                          else if (m_since == SETTLE_CYCLES) enter(M_RUN);
                M_RUN:    if (!m_locked_now) enter(M_LOST);
                M_LOST:   enter(M_WAIT);
                default:  ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [9:0] exp_v, act_v;
        logic e_led, e_stdy;
        if (m_valid) begin
            e_stdy = m_pulse_seen && ((m_edge - m_pulse_start) < STDY_RST_CYCLES);
            if (m_mode == M_RUN)        e_led = 1'b1;
            else if (m_mode == M_FAULT) e_led = 1'(m_blink >> (BLINK_BIT - 2));
            else if (m_mode == M_IDLE)  e_led = 1'b0;
            else                        e_led = 1'(m_blink >> BLINK_BIT);
            exp_v = {3'(m_mode), m_mode != M_RUN, m_mode == M_RUN, m_mode == M_FAULT,
                     e_stdy, 2'(m_loss), e_led};
            act_v = {state, sys_rst, ready, fault, stdy_rst, loss_cnt, status_led};
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL model_cmp t=%0t: got %b required %b (state,sys_rst,ready,fault,stdy_rst,loss_cnt,led)",
                         $time, act_v, exp_v);
            else
                n_pass++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h required %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string nm);
        int k = 0;
        while (state !== tgt && k < budget) begin
            cyc(1);
            k++;
        end
        chk(nm, 32'(state), 32'(tgt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // T1: reset, then lock from edge 10
        rst = 1; pll_locked = 0; pll_stdy = 0;
        cyc(3);
        chk("t1_reset", {state, sys_rst, stdy_rst, ready, fault, loss_cnt, status_led}, 10'b000_1_0_0_0_00_0);
        rst = 0;
        cyc(1); chk("t1_wait_entry", {state, stdy_rst}, {3'd1, 1'b1});
        cyc(3); chk("t1_pulse_last", stdy_rst, 1'b1);
        cyc(1); chk("t1_pulse_end", stdy_rst, 1'b0);
        cyc(1); pll_locked = 1; pll_stdy = 1;
        cyc(2); chk("t1_edge11", state, 3'd1);
        cyc(1); chk("t1_settle12", state, 3'd2);
        cyc(7); chk("t1_edge19", state, 3'd2);
        cyc(1); chk("t1_run20", {state, sys_rst, ready, status_led}, {3'd3, 1'b0, 1'b1, 1'b1});

        // T4: stdy drop in RUN
        pll_stdy = 0;
        cyc(1); chk("t4_M", state, 3'd3);
        cyc(1); chk("t4_M1_sysrst", sys_rst, 1'b0);
        cyc(1); chk("t4_M2_lost", {state, sys_rst, loss_cnt}, {3'd4, 1'b1, 2'd1});
        pll_stdy = 1;
        cyc(1); chk("t4_M3_wait", {state, stdy_rst}, {3'd1, 1'b1});
        wait_state(3'd3, 30, "t4_relock_run");

        // T5: saturating loss counter
        for (int k = 2; k <= 5; k++) begin
            pll_stdy = 0;
            cyc(1);
            pll_stdy = 1;
            cyc(2);
            chk("t5_loss", {state, loss_cnt}, {3'd4, 2'(k > 3 ? 3 : k)});
            wait_state(3'd3, 30, "t5_relock_run");
        end

        // T6a: reset mid-RUN
        rst = 1;
        cyc(1);
        chk("t6a_reset", {state, sys_rst, stdy_rst, ready, fault, loss_cnt, status_led}, 10'b000_1_0_0_0_00_0);
        rst = 0;

        // T3: single-sample pll_locked glitch in SETTLE
        wait_state(3'd2, 20, "t3_settle");
        cyc(5); pll_locked = 0;
        cyc(1); pll_locked = 1;
        cyc(2); chk("t3_back_to_wait", {state, stdy_rst, loss_cnt}, {3'd1, 1'b1, 2'd0});
        cyc(3); chk("t3_pulse_last", stdy_rst, 1'b1);
        cyc(1); chk("t3_pulse_end", {state, stdy_rst}, {3'd2, 1'b0});
        cyc(4); chk("t3_still_settle", state, 3'd2);
        cyc(1); chk("t3_run", {state, ready}, {3'd3, 1'b1});

        // T6b: reset mid-pulse
        rst = 1; cyc(1); rst = 0;
        cyc(2); chk("t6b_in_pulse", stdy_rst, 1'b1);
        rst = 1; pll_locked = 0; pll_stdy = 0;
        cyc(1);
        chk("t6b_reset", {state, sys_rst, stdy_rst, ready, fault, loss_cnt, status_led}, 10'b000_1_0_0_0_00_0);

        // T2: no lock -> FAULT
        cyc(2); rst = 0;
        cyc(64); chk("t2_edge64", state, 3'd1);
        cyc(1); chk("t2_fault", {state, fault, sys_rst, status_led}, {3'd5, 1'b1, 1'b1, 1'b0});
        pll_locked = 1; pll_stdy = 1;
        cyc(1); chk("t2_led66", status_led, 1'b1);
        cyc(1); chk("t2_led67", status_led, 1'b1);
        cyc(1); chk("t2_led68", status_led, 1'b0);
        cyc(20); chk("t2_sticky", {state, fault}, {3'd5, 1'b1});

        // Randomized phase
        rst = 1; cyc(2); rst = 0;
        for (int s = 0; s < 200; s++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                rst = 1; cyc($urandom_range(1, 2)); rst = 0;
            end else if (r < 7) begin
                pll_locked = 0; pll_stdy = 0; cyc(70);
            end else begin
                if (r < 60) begin
                    pll_locked = 1; pll_stdy = 1;
                end else begin
                    pll_locked = 1'($urandom_range(0, 1));
                    pll_stdy   = 1'($urandom_range(0, 1));
                end
                cyc($urandom_range(1, 24));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
